// File: rtl/hk_spi_scheduler_if.sv
// Buses around the housekeeping SPI scheduler: requester side (hk_req_if)
// and the shared spi_master start/data/busy side (hk_spi_if).
interface hk_req_if #(
    parameter int NR = 2,
    parameter int DW = 16
);
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] wr_h;
    logic [NR*DW-1:0] wr_l;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic [NR-1:0]    err;
    logic [DW-1:0]    rd_dat;
    logic             busy;

    // master = the requesters, slave = the scheduler
    modport master (output req, wr_h, wr_l, input gnt, done, err, rd_dat, busy);
    modport slave  (input req, wr_h, wr_l, output gnt, done, err, rd_dat, busy);
endinterface

interface hk_spi_if #(
    parameter int DW = 16
);
    logic          start;
    logic [DW-1:0] wr_h;
    logic [DW-1:0] wr_l;
    logic          busy;
    logic [DW-1:0] rd_l;

    // master = the scheduler, slave = the shared spi_master
    modport master (output start, wr_h, wr_l, input busy, rd_l);
    modport slave  (input start, wr_h, wr_l, output busy, rd_l);
endinterface

// File: rtl/hk_spi_scheduler.sv
// Round-robin sharing of one spi_master between NR requesters, with write words
// held for the whole transaction and start/busy timeouts reported as err pulses.
module hk_spi_scheduler #(
    parameter int NR       = 2,
    parameter int DW       = 16,
    parameter int BSY_WAIT = 8,
    parameter int TMO      = 65535
) (
    input  logic      clk_i,
    input  logic      rst_i,
    hk_req_if.slave   req_bus,
    hk_spi_if.master  spi_bus
);
    localparam int          IW      = $clog2(NR);
    // The start timeout fires one cycle earlier in its count than the busy timeout.
    localparam logic [15:0] BSY_LIM = 16'(BSY_WAIT - 1);
    localparam logic [15:0] TMO_LIM = 16'(TMO);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_BSY, S_RUN, S_DONE, S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] last_q, win_idx, cand;
    logic          win_vld;
    logic [NR-1:0] win_oh, gnt_q;
    logic [DW-1:0] wr_h_q, wr_l_q, rd_q;
    logic [15:0]   cnt_q;
    logic          grant_en, cnt_clr, rd_cap;

    // Search starts just after the last winner, so a re-request yields to the others.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NR; i++) begin
            cand = IW'((int'(last_q) + i) % NR);
            if (!win_vld && req_bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        grant_en = 1'b0;
        cnt_clr  = 1'b0;
        rd_cap   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_en = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                cnt_clr = 1'b1;
                state_d = S_WAIT_BSY;
            end
            S_WAIT_BSY: begin
                if (spi_bus.busy) begin
                    cnt_clr = 1'b1;
                    state_d = S_RUN;
                end else if (cnt_q >= BSY_LIM) begin
                    state_d = S_FAIL;
                end
            end
            S_RUN: begin
                if (!spi_bus.busy) begin
                    rd_cap  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q >= TMO_LIM) begin
                    state_d = S_FAIL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IW'(NR - 1);
            gnt_q  <= '0;
            wr_h_q <= '0;
            wr_l_q <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (grant_en) begin
                last_q <= win_idx;
                gnt_q  <= win_oh;
                wr_h_q <= req_bus.wr_h[int'(win_idx) * DW +: DW];
                wr_l_q <= req_bus.wr_l[int'(win_idx) * DW +: DW];
            end else if (state_q == S_DONE || state_q == S_FAIL) begin
                gnt_q <= '0;
            end
            if (rd_cap) rd_q <= spi_bus.rd_l;
            if (cnt_clr)                 cnt_q <= '0;
            else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign req_bus.gnt    = gnt_q;
    assign req_bus.done   = (state_q == S_DONE) ? gnt_q : '0;
    assign req_bus.err    = (state_q == S_FAIL) ? gnt_q : '0;
    assign req_bus.rd_dat = rd_q;
    assign req_bus.busy   = (state_q != S_IDLE);
    assign spi_bus.start  = (state_q == S_START);
    assign spi_bus.wr_h   = wr_h_q;
    assign spi_bus.wr_l   = wr_l_q;
endmodule

// File: tb/tb_hk_spi_scheduler.sv
// Scoreboard bench for hk_spi_scheduler: directed requests push expected pulses,
// a negedge monitor pops and compares them against a simple spi_master model.
module tb_hk_spi_scheduler;
    localparam int NR       = 2;
    localparam int DW       = 16;
    localparam int BSY_WAIT = 8;
    localparam int TMO      = 100;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    hk_req_if #(.NR(NR), .DW(DW)) req_bus ();
    hk_spi_if #(.DW(DW))          spi_bus ();

    hk_spi_scheduler #(.NR(NR), .DW(DW), .BSY_WAIT(BSY_WAIT), .TMO(TMO)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_bus (req_bus),
        .spi_bus (spi_bus)
    );

    typedef enum int {REF_FALL, REF_START, REF_RUN} ref_t;
    typedef struct {
        logic        is_err;
        int          idx;
        logic [15:0] rd, wh, wl;
        ref_t        ref_ev;
        int          lat;
    } exp_t;
    typedef enum int {M_NORMAL, M_NEVER, M_STUCK} mode_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    mode_t       mode = M_NORMAL;
    int          busy_len = 4;
    logic [15:0] rd_xor = '0;

    int          cyc = 0, start_cyc = 0, rise_cyc = 0, fall_cyc = 0, start_cnt = 0;
    logic        seen_rise = 0, seen_fall = 0, words_bad = 0, pend_idle = 0;
    logic [15:0] w_h = '0, w_l = '0;
    logic [NR-1:0] gnt_prev = '0;
    int          gnt_rise[NR] = '{default: 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic is_err, input int idx, input logic [15:0] rd,
                        input logic [15:0] wh, input logic [15:0] wl, input ref_t r, input int lat);
        exp_t e;
        e.is_err = is_err; e.idx = idx; e.rd = rd; e.wh = wh; e.wl = wl;
        e.ref_ev = r; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic set_words(input int k, input logic [15:0] wh, input logic [15:0] wl);
        req_bus.wr_h[k*DW +: DW] = wh;
        req_bus.wr_l[k*DW +: DW] = wl;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_ctl"}, 64'({req_bus.gnt, req_bus.done, req_bus.err, req_bus.busy, spi_bus.start}), 64'd0);
        check({pfx, "_rd_dat"}, 64'(req_bus.rd_dat), 64'd0);
        check({pfx, "_words"}, 64'({spi_bus.wr_h, spi_bus.wr_l}), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        req_bus.req = '0;
        repeat (2) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_i = 1'b0;
    endtask

    // Raise req[k] and hold it until the scheduler pulses done/err for k.
    task automatic serve(input int k, input int budget);
        logic got = 1'b0;
        @(negedge clk_i);
        req_bus.req[k] = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk_i);
            if (req_bus.done[k] || req_bus.err[k]) begin
                req_bus.req[k] = 1'b0;
                got = 1'b1;
            end
        end
        check("pulse_seen", 64'(got), 64'd1);
        req_bus.req[k] = 1'b0;
    endtask

    task automatic wait_gnt(input int k, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk_i);
            got = req_bus.gnt[k];
        end
        check("grant_seen", 64'(got), 64'd1);
    endtask

    // Both requesters hold req until each has received n done pulses.
    task automatic hold_both(input int n, input int budget);
        int c0 = 0, c1 = 0;
        @(negedge clk_i);
        req_bus.req = 2'b11;
        for (int i = 0; i < budget && req_bus.req != '0; i++) begin
            @(negedge clk_i);
            if (req_bus.done[0]) begin c0++; if (c0 == n) req_bus.req[0] = 1'b0; end
            if (req_bus.done[1]) begin c1++; if (c1 == n) req_bus.req[1] = 1'b0; end
        end
        check("hold_both_released", 64'(req_bus.req), 64'd0);
        req_bus.req = '0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk_i);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    // spi_master model: busy follows start by one cycle; read data = wr_l ^ rd_xor.
    initial begin
        logic saw;
        int   m_left;
        spi_bus.busy = 1'b0;
        spi_bus.rd_l = '0;
        m_left = 0;
        forever begin
            @(negedge clk_i);
            saw = spi_bus.start;
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                spi_bus.busy = 1'b0;
                m_left = 0;
            end else if (saw) begin
                spi_bus.rd_l = spi_bus.wr_l ^ rd_xor;
                case (mode)
                    M_NORMAL: begin spi_bus.busy = (busy_len > 0); m_left = busy_len - 1; end
                    M_NEVER:  spi_bus.busy = 1'b0;
                    default:  spi_bus.busy = 1'b1;
                endcase
            end else if (mode == M_STUCK) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                spi_bus.busy = 1'b0;
            end
        end
    end

    // Monitor: tracks start/busy edges and checks every done/err pulse against the scoreboard.
    initial begin
        exp_t          e;
        logic [NR-1:0] oh;
        int            refc;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                start_cnt = 0; seen_rise = 0; seen_fall = 0; pend_idle = 0; gnt_prev = '0;
            end else begin
                if (pend_idle) begin
                    check("busy_low_after_pulse", 64'(req_bus.busy), 64'd0);
                    pend_idle = 0;
                end
                for (int k = 0; k < NR; k++)
                    if (req_bus.gnt[k] && !gnt_prev[k]) gnt_rise[k]++;
                gnt_prev = req_bus.gnt;
                if (spi_bus.start) begin
                    start_cnt++;
                    start_cyc = cyc;
                    w_h = spi_bus.wr_h;
                    w_l = spi_bus.wr_l;
                    words_bad = 0; seen_rise = 0; seen_fall = 0;
                end else if (req_bus.busy) begin
                    if (spi_bus.wr_h !== w_h || spi_bus.wr_l !== w_l) words_bad = 1;
                    if (!seen_rise && spi_bus.busy) begin
                        seen_rise = 1; rise_cyc = cyc;
                    end else if (seen_rise && !seen_fall && !spi_bus.busy) begin
                        seen_fall = 1; fall_cyc = cyc;
                    end
                end
                if ((req_bus.done | req_bus.err) != '0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 64'({req_bus.done, req_bus.err}), 64'd0);
                    end else begin
                        e  = sb.pop_front();
                        oh = NR'(1) << e.idx;
                        check("pulse_vector", 64'({req_bus.done, req_bus.err}),
                              e.is_err ? 64'(oh) : (64'(oh) << NR));
                        check("gnt_in_pulse", 64'(req_bus.gnt), 64'(oh));
                        check("rd_dat", 64'(req_bus.rd_dat), 64'(e.rd));
                        check("start_pulses", 64'(start_cnt), 64'd1);
                        check("spi_words", 64'({w_h, w_l}), 64'({e.wh, e.wl}));
                        check("words_stable", 64'(words_bad), 64'd0);
                        case (e.ref_ev)
                            REF_FALL:  refc = seen_fall ? fall_cyc : -100000;
                            REF_START: refc = start_cyc;
                            default:   refc = seen_rise ? rise_cyc + 1 : -100000;
                        endcase
                        check("pulse_latency", 64'(cyc - refc), 64'(e.lat));
                    end
                    start_cnt = 0;
                    pend_idle = 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before 50000 cycles");
        $fatal(1);
    end

    initial begin
        int g1;
        req_bus.req  = '0;
        req_bus.wr_h = '0;
        req_bus.wr_l = '0;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_i = 1'b0;

        // Single requester 0, master busy 20 cycles, returns 0x0042.
        mode = M_NORMAL; busy_len = 20; rd_xor = 16'h00E7;
        set_words(0, 16'h8012, 16'h00A5);
        push(1'b0, 0, 16'h0042, 16'h8012, 16'h00A5, REF_FALL, 1);
        serve(0, 200);
        drain(50);
        check("rd_held_after_done", 64'(req_bus.rd_dat), 64'h0042);

        // Simultaneous requests straight after reset: 0 then 1, then alternating.
        do_reset();
        busy_len = 4; rd_xor = '0;
        set_words(0, 16'h1000, 16'h0001);
        set_words(1, 16'h2000, 16'h0002);
        push(1'b0, 0, 16'h0001, 16'h1000, 16'h0001, REF_FALL, 1);
        push(1'b0, 1, 16'h0002, 16'h2000, 16'h0002, REF_FALL, 1);
        hold_both(1, 400);
        drain(50);
        for (int r = 0; r < 2; r++) begin
            push(1'b0, 0, 16'h0001, 16'h1000, 16'h0001, REF_FALL, 1);
            push(1'b0, 1, 16'h0002, 16'h2000, 16'h0002, REF_FALL, 1);
        end
        hold_both(2, 800);
        drain(50);

        // Master never raises busy: start timeout on requester 1, rd_dat held.
        mode = M_NEVER;
        set_words(1, 16'h3333, 16'h4444);
        push(1'b1, 1, 16'h0002, 16'h3333, 16'h4444, REF_START, BSY_WAIT + 1);
        serve(1, 100);
        drain(20);
        check("rd_held_after_start_tmo", 64'(req_bus.rd_dat), 64'h0002);

        // Busy stuck high: busy timeout TMO+1 cycles after entering RUN.
        mode = M_STUCK;
        set_words(0, 16'h5555, 16'h6666);
        push(1'b1, 0, 16'h0002, 16'h5555, 16'h6666, REF_RUN, TMO + 1);
        serve(0, 400);
        drain(20);
        mode = M_NORMAL;
        repeat (3) @(negedge clk_i);

        // Requester 1 drops req mid-transaction: still completes.
        busy_len = 6; rd_xor = '0;
        set_words(1, 16'h7777, 16'h0123);
        push(1'b0, 1, 16'h0123, 16'h7777, 16'h0123, REF_FALL, 1);
        @(negedge clk_i);
        req_bus.req[1] = 1'b1;
        wait_gnt(1, 20);
        repeat (3) @(negedge clk_i);
        req_bus.req[1] = 1'b0;
        drain(100);

        // Requester 1 drops req before being granted: never served.
        set_words(0, 16'h0000, 16'h0ABC);
        set_words(1, 16'h1234, 16'h5678);
        push(1'b0, 0, 16'h0ABC, 16'h0000, 16'h0ABC, REF_FALL, 1);
        g1 = gnt_rise[1];
        @(negedge clk_i);
        req_bus.req = 2'b11;
        wait_gnt(0, 20);
        req_bus.req[1] = 1'b0;
        for (int i = 0; i < 100 && req_bus.req[0]; i++) begin
            @(negedge clk_i);
            if (req_bus.done[0]) req_bus.req[0] = 1'b0;
        end
        req_bus.req = '0;
        drain(50);
        repeat (10) @(negedge clk_i);
        check("dropped_req_not_granted", 64'(gnt_rise[1] - g1), 64'd0);

        // Reset while in RUN: outputs clear next cycle, no pulse, then normal service.
        mode = M_STUCK;
        set_words(0, 16'h2468, 16'h1357);
        @(negedge clk_i);
        req_bus.req[0] = 1'b1;
        wait_gnt(0, 20);
        repeat (6) @(negedge clk_i);
        rst_i = 1'b1;
        req_bus.req = '0;
        @(negedge clk_i);
        check_idle_outputs("reset_in_run");
        rst_i = 1'b0;
        mode = M_NORMAL;
        repeat (3) @(negedge clk_i);
        busy_len = 3; rd_xor = '0;
        set_words(0, 16'h9ABC, 16'h0DEF);
        push(1'b0, 0, 16'h0DEF, 16'h9ABC, 16'h0DEF, REF_FALL, 1);
        serve(0, 100);
        drain(50);
        repeat (2) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
